// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the signed multiply/divide unit: command encodings,
// FSM state enum, datapath widths and the iteration count.
package muldiv_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ACC_W   = 2 * XLEN;
  localparam int unsigned MD_ITER = 32;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_NOP  = 2'b11
  } md_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [XLEN-1:0] md_abs(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Command/result bundle between the control unit (master) and muldiv_unit (slave).
//   mult_div : command (00/11 idle, 01 multiply, 10 divide)
//   a, b     : operands
//   hi, lo   : result halves (product / remainder, quotient)
//   busy     : operation in flight, commands ignored
//   done     : one-cycle result-valid pulse
//   div0     : last divide had a zero divisor
interface muldiv_unit_if;
  logic [1:0]  mult_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  modport master (output mult_div, a, b, input hi, lo, busy, done, div0);
  modport slave  (input mult_div, a, b, output hi, lo, busy, done, div0);
endinterface

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: 64-bit shift register, 33-bit adder/subtractor
// and iteration counter. Multiply is right-shift shift-add; divide (only when
// MULDIV_DIV_EN is defined) is left-shift restoring shift-subtract.
//   load  : capture magnitudes, clear accumulator upper half and counter
//   step  : perform one iteration
//   acc   : {upper, lower} = product, or {remainder, quotient}
//   cnt   : iterations completed
module muldiv_core
  import muldiv_unit_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [XLEN-1:0]  mag_a,
  input  logic [XLEN-1:0]  mag_b,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] cnt
);

  logic [XLEN-1:0]  divisor;
  logic [ACC_W-1:0] acc_d;
  logic [XLEN:0]    sum;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]    diff;
`else
  logic             unused_is_div;
  assign unused_is_div = is_div;
`endif

  // One iteration; the carry out of the add becomes the new top bit.
  always_comb begin
    sum   = {1'b0, acc[ACC_W-1:XLEN]} + {1'b0, divisor};
    acc_d = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[ACC_W-1:1]};
`ifdef MULDIV_DIV_EN
    // Partial remainder after the shift is acc[63:31]; a borrow means restore.
    diff = acc[ACC_W-1:XLEN-1] - {1'b0, divisor};
    if (is_div) begin
      acc_d = diff[XLEN] ? {acc[ACC_W-2:0], 1'b0}
                         : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      divisor <= '0;
      cnt     <= '0;
    end else if (load) begin
      acc     <= {{XLEN{1'b0}}, mag_a};
      divisor <= mag_b;
      cnt     <= '0;
    end else if (step) begin
      acc     <= acc_d;
      cnt     <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Signed 32x32 multiply / 32/32 divide unit with a 34-cycle start-to-done latency.
// Optional divide support is built when MULDIV_DIV_EN is defined; otherwise
// the divide command is treated as idle and div0 is constant 0.
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : muldiv_unit_if slave (mult_div, a, b in; hi, lo, busy, done, div0 out)
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  md_state_e        state_q, state_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             neg_q, neg_d;
  logic             load, step, is_div;
  logic [ACC_W-1:0] acc, prod_fix;
  logic [CNT_W-1:0] cnt;
`ifdef MULDIV_DIV_EN
  logic             div_q, div_d, rem_neg_q, rem_neg_d, div0_q, div0_d;
  logic [XLEN-1:0]  quo_fix, rem_fix;

  assign is_div   = div_q;
  assign quo_fix  = neg_q ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
  assign rem_fix  = rem_neg_q ? XLEN'(-acc[ACC_W-1:XLEN]) : acc[ACC_W-1:XLEN];
  assign bus.div0 = div0_q;
`else
  assign is_div   = 1'b0;
  assign bus.div0 = 1'b0;
`endif

  assign prod_fix = neg_q ? ACC_W'(-acc) : acc;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  muldiv_core u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (is_div),
    .mag_a  (md_abs(bus.a)),
    .mag_b  (md_abs(bus.b)),
    .acc    (acc),
    .cnt    (cnt)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    load    = 1'b0;
    step    = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d     = div_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.mult_div == MD_MULT) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          neg_d   = bus.a[XLEN-1] ^ bus.b[XLEN-1];
          state_d = ST_CALC;
`ifdef MULDIV_DIV_EN
          div_d   = 1'b0;
          div0_d  = 1'b0;
        end else if (bus.mult_div == MD_DIV) begin
          load      = 1'b1;
          busy_d    = 1'b1;
          neg_d     = bus.a[XLEN-1] ^ bus.b[XLEN-1];
          rem_neg_d = bus.a[XLEN-1];
          div_d     = 1'b1;
          // Zero divisor skips the iterations; FIX then only flags it.
          div0_d    = (bus.b == '0);
          state_d   = (bus.b == '0) ? ST_FIX : ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (cnt == CNT_W'(MD_ITER)) state_d = ST_FIX;
        else                        step    = 1'b1;
      end
      ST_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          if (!div0_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else
`endif
        begin
          hi_d = prod_fix[ACC_W-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Registered outputs and per-operation sign bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      neg_q  <= neg_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit. Divide vectors run when
// MULDIV_DIV_EN is defined; otherwise the divide command is checked as ignored.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   ndone;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a command for exactly one sampling edge, then scramble operands.
  task automatic start_only(input logic [1:0] cmd, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clock);
    bus.mult_div = cmd;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clock);
    #1;
    bus.mult_div = 2'b00;
    bus.a        = ~av;
    bus.b        = bv + 32'd7;
  endtask

  // Start an operation and return the edge count until done (-1 on timeout).
  task automatic run_op(input logic [1:0] cmd, input logic [31:0] av, input logic [31:0] bv,
                        output int edges);
    start_only(cmd, av, bv);
    check("busy_after_start", 64'(bus.busy), 64'(1));
    edges = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        edges = e;
        break;
      end
    end
  endtask

  function automatic logic [63:0] res();
    return {bus.hi, bus.lo};
  endfunction

  initial begin
    bus.mult_div = 2'b00;
    bus.a        = '0;
    bus.b        = '0;
    #12;
    check("reset_hilo", res(), 64'h0);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_div0", 64'(bus.div0), 64'(0));
    @(posedge clock);
    #1 reset = 1'b0;

    // First command after reset, small signed multiply.
    run_op(2'(MD_MULT), 32'd7, 32'hFFFF_FFFD, lat);
    check("mul_7_m3_lat", 64'(lat), 64'(34));
    check("mul_7_m3", res(), 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul_not_busy_at_done", 64'(bus.busy), 64'(0));

    // Back-to-back: issued in the done cycle.
    run_op(2'(MD_MULT), 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat);
    check("b2b_lat", 64'(lat), 64'(34));
    check("mul_maxpos_sq", res(), 64'h3FFF_FFFF_0000_0001);
    @(posedge clock);
    #1;
    check("done_one_cycle", 64'(bus.done), 64'(0));
    repeat (3) @(posedge clock);
    #1;
    check("hilo_hold", res(), 64'h3FFF_FFFF_0000_0001);

    run_op(2'(MD_MULT), 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("mul_m1_m1", res(), 64'h0000_0000_0000_0001);
    run_op(2'(MD_MULT), 32'h8000_0000, 32'h8000_0000, lat);
    check("mul_min_min", res(), 64'h4000_0000_0000_0000);
    run_op(2'(MD_MULT), 32'h8000_0000, 32'd1, lat);
    check("mul_min_1", res(), 64'hFFFF_FFFF_8000_0000);
    run_op(2'(MD_MULT), 32'd0, 32'hFFFF_FFFB, lat);
    check("mul_0_m5", res(), 64'h0);

    // Command at edge 5 of a busy multiply must be ignored.
    start_only(2'(MD_MULT), 32'h1234_5678, 32'h0000_0010);
    ndone = 0;
    lat   = -1;
    for (int e = 1; e <= 60; e++) begin
      if (e == 5) begin
        @(negedge clock);
        bus.mult_div = 2'(MD_DIV);
        bus.a        = 32'd5;
        bus.b        = 32'd0;
      end
      @(posedge clock);
      #1;
      if (e == 5) bus.mult_div = 2'b00;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = e;
      end
    end
    check("busy_ignore_ndone", 64'(ndone), 64'(1));
    check("busy_ignore_lat", 64'(lat), 64'(34));
    check("busy_ignore_res", res(), 64'h0000_0001_2345_6780);
    check("busy_ignore_div0", 64'(bus.div0), 64'(0));

`ifdef MULDIV_DIV_EN
    run_op(2'(MD_DIV), 32'hFFFF_FFF9, 32'd2, lat);
    check("div_m7_2_lat", 64'(lat), 64'(34));
    check("div_m7_2", res(), 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_m7_2_div0", 64'(bus.div0), 64'(0));
    run_op(2'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_min_m1", res(), 64'h0000_0000_8000_0000);
    check("div_min_m1_div0", 64'(bus.div0), 64'(0));
    run_op(2'(MD_DIV), 32'd7, 32'hFFFF_FFFE, lat);
    check("div_7_m2", res(), 64'h0000_0001_FFFF_FFFD);
    run_op(2'(MD_DIV), 32'd100, 32'd7, lat);
    check("div_100_7", res(), 64'h0000_0002_0000_000E);
    run_op(2'(MD_DIV), 32'd5, 32'd0, lat);
    check("div0_lat", 64'(lat), 64'(1));
    check("div0_flag", 64'(bus.div0), 64'(1));
    check("div0_hilo_kept", res(), 64'h0000_0002_0000_000E);
    repeat (2) @(posedge clock);
    #1;
    check("div0_held", 64'(bus.div0), 64'(1));
    run_op(2'(MD_MULT), 32'd2, 32'd3, lat);
    check("div0_cleared", 64'(bus.div0), 64'(0));
    check("mul_after_div0", res(), 64'h6);
`else
    start_only(2'(MD_DIV), 32'd5, 32'd0);
    check("div_disabled_busy", 64'(bus.busy), 64'(0));
    ndone = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      if (bus.done) ndone++;
    end
    check("div_disabled_ndone", 64'(ndone), 64'(0));
    check("div_disabled_div0", 64'(bus.div0), 64'(0));
    check("div_disabled_hilo", res(), 64'h0000_0001_2345_6780);
`endif

    // Reset in flight: outputs clear at once and the old operation never completes.
    start_only(2'(MD_MULT), 32'd9, 32'd9);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("rst_inflight_hilo", res(), 64'h0);
    check("rst_inflight_busy", 64'(bus.busy), 64'(0));
    check("rst_inflight_done", 64'(bus.done), 64'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    ndone = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) ndone++;
    end
    check("rst_no_done_after", 64'(ndone), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL: mult_div  input  2  command from control unit: 00 idle, 01 start signed multiply, 10 start signed divide, 11 idle.
REQ-004 SHALL: a  input  32  operand A (multiplicand / dividend), two's complement.
REQ-005 SHALL: b  input  32  operand B (multiplier / divisor), two's complement.
REQ-006 SHALL: hi  output  32  product bits 63:32 / remainder.
REQ-007 SHALL: lo  output  32  product bits 31:0 / quotient.
REQ-008 SHALL: busy  output  1  operation in progress; commands ignored.
REQ-009 SHALL: done  output  1  one-cycle pulse; hi/lo (or div0) valid.
REQ-010 SHALL: div0  output  1  last divide had b=0; held until next accepted command.

Function
REQ-011 SHALL: FSM states IDLE, CALC, FIX; command sampled only when busy=0.
REQ-012 SHALL: on an accepted start edge, latch a and b, store magnitudes and result sign, clear iteration counter to 0, go to CALC, set busy=1.
REQ-013 SHALL: CALC runs exactly 32 iterations, one per edge (shift-add for multiply, restoring shift-subtract for divide), then go to FIX.
REQ-014 SHALL: FIX applies sign correction, writes hi/lo, pulses done=1, clears busy, returns to IDLE; done rises 34 edges after the start-sampling edge.
REQ-015 SHALL: multiply: 64-bit signed product {hi,lo}; negated iff a[31]^b[31].
REQ-016 SHALL: divide: lo=quotient truncated toward zero (negated iff a[31]^b[31]); hi=remainder carrying sign of a.
REQ-017 SHALL: a=0x80000000, b=0xFFFFFFFF divide gives lo=0x80000000, hi=0; no flag.
REQ-018 SHALL: divide with b=0: no CALC; on the edge after the start edge done=1, div0=1; hi/lo unchanged.
REQ-019 SHALL: commands arriving while busy=1 have no effect; a command present in the done cycle is accepted (back-to-back).
REQ-020 SHALL: hi/lo hold their values between operations; they change only in FIX or on reset.
REQ-021 SHALL: operand changes on a/b after the start edge do not affect the result.

Reset
REQ-022 SHALL: on reset: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div0=0; an operation in flight is discarded.
REQ-023 SHALL: first command after reset deassertion is accepted on the first rising edge with reset=0.

Configuration
REQ-024 SHALL: macro MULDIV_DIV_EN defined: divide path and div0 present as specified.
REQ-025 SHALL: MULDIV_DIV_EN undefined: mult_div=10 treated as idle (no busy, no done), div0 tied 0, divide datapath absent; multiply timing unchanged.

Structure
REQ-026 SHALL: shared package holds command encodings (MD_IDLE, MD_MULT, MD_DIV), FSM state enum, and MD_ITER=32.
REQ-027 SHALL: one sub-module muldiv_core holds the 64-bit shift register, adder/subtractor, and counter; FSM and sign correction stay in muldiv_unit.

Verification
REQ-028 SHALL: mult a=7, b=0xFFFFFFFD (-3) -> done at edge 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-029 SHALL: mult a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
REQ-030 SHALL: div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div0=0.
REQ-031 SHALL: div a=5, b=0 -> done and div0 at edge 1, hi/lo keep prior values; next mult clears div0.
REQ-032 SHALL: mult started, reset asserted at edge 10 -> all outputs 0 immediately, no done pulse afterwards.
REQ-033 SHALL: div issued at edge 5 during a busy mult -> ignored; only one done, with mult result.
